// File: rtl/unique_cmp_pkg.sv
// -----------------------------------------------------------------------------
// unique_cmp_pkg
// Shared types and defaults for the unique/priority compare checker.
//   cmp_mode_e    : CMP_PRIORITY (first match wins, multiple matches silent)
//                   CMP_UNIQUE   (multiple matches counted as a violation)
//   DEF_*         : default parameter values for the checker and its interface
//   MAX_NCH       : widest hit vector popcount_gt1 accepts (zero-extend narrower)
//   popcount_gt1  : true when more than one bit of a hit vector is set
// -----------------------------------------------------------------------------
package unique_cmp_pkg;

    typedef enum logic {
        CMP_PRIORITY = 1'b0,
        CMP_UNIQUE   = 1'b1
    } cmp_mode_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NCH   = 2;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_NCH   = 64;

    // Clearing the lowest set bit (x & (x-1)) leaves something behind only
    // when at least two bits were set, so no adder tree is needed.
    function automatic logic popcount_gt1(input logic [MAX_NCH-1:0] hit);
        logic [MAX_NCH-1:0] rest;
        rest = hit & (hit - MAX_NCH'(1));
        return |rest;
    endfunction

endpackage

// File: rtl/unique_cmp_checker_if.sv
// -----------------------------------------------------------------------------
// unique_cmp_checker_if
// Bundles the operand handshake, result handshake and violation counter
// signals of unique_cmp_checker.
//   master modport : producer/consumer side (drives operands, out_ready, clr_cnt)
//   slave  modport : checker side (drives in_ready and all results)
// Parameters must match those of the checker instance it is connected to.
// -----------------------------------------------------------------------------
interface unique_cmp_checker_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
);
    localparam int IDX_W = $clog2(NCH);

    // operand side
    logic                   mode;       // 0 = priority, 1 = unique
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [NCH*WIDTH-1:0]   thr;        // channel i = thr[i*WIDTH +: WIDTH]

    // result side
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_hit;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_multi;
    logic                   out_viol;

    // violation counter
    logic                   clr_cnt;
    logic [CNT_W-1:0]       viol_cnt;

    modport master (
        output mode, in_valid, a, thr, out_ready, clr_cnt,
        input  in_ready, out_valid, out_hit, out_idx, out_multi, out_viol, viol_cnt
    );

    modport slave (
        input  mode, in_valid, a, thr, out_ready, clr_cnt,
        output in_ready, out_valid, out_hit, out_idx, out_multi, out_viol, viol_cnt
    );

endinterface

// File: rtl/unique_cmp_checker_prio_encoder.sv
// -----------------------------------------------------------------------------
// prio_encoder
// Combinational lowest-index-wins encoder.
//   hit [N-1:0]          : match vector, bit i = channel i matched
//   any                  : at least one bit of hit set
//   idx [$clog2(N)-1:0]  : index of the lowest set bit, 0 when nothing is set
// N must be at least 2 so that idx has a non-zero width.
// -----------------------------------------------------------------------------
module prio_encoder #(
    parameter int N = 2
) (
    input  logic [N-1:0]          hit,
    output logic                  any,
    output logic [$clog2(N)-1:0]  idx
);
    localparam int IDX_W = $clog2(N);

    always_comb begin
        any = |hit;
        idx = '0;
        // Walk from the top down so the lowest set bit is the last write.
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/unique_cmp_checker.sv
// -----------------------------------------------------------------------------
// unique_cmp_checker
// Registered N-channel compare/decode stage. One operand A is tested against
// NCH thresholds (A < THR[i], unsigned); the lowest matching channel is
// reported and multiple matches are flagged. In unique mode a multiple match
// is a violation and is counted in a saturating counter.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus.slave  : operand handshake (mode, in_valid/in_ready, a, thr),
//                result handshake (out_valid/out_ready, out_hit, out_idx,
//                out_multi, out_viol), counter clear clr_cnt and viol_cnt
// Single output register, no skid buffer: in_ready = !out_valid || out_ready.
// Latency is one cycle; one result per cycle with out_ready held high.
// -----------------------------------------------------------------------------
module unique_cmp_checker
    import unique_cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unique_cmp_checker_if.slave   bus
);
    localparam int               IDX_W   = $clog2(NCH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Compare and decode (combinational, on the incoming operand)
    // ------------------------------------------------------------------
    logic [NCH-1:0]     hit;
    logic [MAX_NCH-1:0] hit_ext;
    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;
    logic               hit_multi;

    // Strict less-than: a == thr[i] is deliberately not a match.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cmp
            assign hit[gi] = (bus.a < bus.thr[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    prio_encoder #(
        .N (NCH)
    ) u_prio_encoder (
        .hit (hit),
        .any (hit_any),
        .idx (hit_idx)
    );

    always_comb begin
        hit_ext          = '0;
        hit_ext[NCH-1:0] = hit;
    end

    assign hit_multi = popcount_gt1(hit_ext);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic out_valid_reg;
    logic out_valid_next;
    logic in_ready;
    logic take;
    logic viol_now;

    assign in_ready = !out_valid_reg || bus.out_ready;
    assign take     = bus.in_valid && in_ready;

    // A violation is counted when it is registered, not when it is consumed,
    // so a result stalled by backpressure is counted exactly once.
    assign viol_now = take && hit_multi && (cmp_mode_e'(bus.mode) == CMP_UNIQUE);

    always_comb begin
        out_valid_next = out_valid_reg;
        if (take) begin
            out_valid_next = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Result and mode registers: load only on a transfer, so a held result
    // (including its mode) ignores anything happening on the inputs.
    // ------------------------------------------------------------------
    logic             hit_reg,   hit_next;
    logic [IDX_W-1:0] idx_reg,   idx_next;
    logic             multi_reg, multi_next;
    cmp_mode_e        mode_reg,  mode_next;

    always_comb begin
        hit_next   = hit_reg;
        idx_next   = idx_reg;
        multi_next = multi_reg;
        mode_next  = mode_reg;
        if (take) begin
            hit_next   = hit_any;
            idx_next   = hit_idx;
            multi_next = hit_multi;
            mode_next  = cmp_mode_e'(bus.mode);
        end
    end

    // ------------------------------------------------------------------
    // Saturating violation counter; clear takes precedence over increment.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (bus.clr_cnt) begin
            cnt_next = '0;
        end else if (viol_now && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            hit_reg       <= 1'b0;
            idx_reg       <= '0;
            multi_reg     <= 1'b0;
            mode_reg      <= CMP_PRIORITY;
            cnt_reg       <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            hit_reg       <= hit_next;
            idx_reg       <= idx_next;
            multi_reg     <= multi_next;
            mode_reg      <= mode_next;
            cnt_reg       <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_hit   = hit_reg;
    assign bus.out_idx   = idx_reg;
    assign bus.out_multi = multi_reg;
    assign bus.out_viol  = multi_reg && (mode_reg == CMP_UNIQUE);
    assign bus.viol_cnt  = cnt_reg;

endmodule
